sram_bist_seq: RTL and testbench
================================

# sram_bist_seq

Sequential write-then-verify engine for a TL-UL-attached memory, driving the SRAM-style request port of the SRAM-to-TL-UL bridge directly upstream of it. On `start_i` it writes an LFSR pattern across an address window, reads the window back one word at a time, and compares each word. It reports pass/fail, a saturating error count and the first failing address. It is used for memory init and self-test before the host boots.

## Interface
- `SramAw`, default 12: word-address width; must match the bridge.
- `SramDw`, default 32: data width; must be 32, because the LFSR is 32-bit.
- `TimeoutCycles`, default 64: maximum wait per read response before aborting.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `start_i`  in  1  level; sampled only in IDLE.
- `start_addr_i`  in  SramAw  first word address; captured at start.
- `last_addr_i`  in  SramAw  last word address, inclusive; captured at start.
- `seed_i`  in  32  LFSR seed; captured at start; a zero seed is replaced by `DefaultSeed`.
- `mem_req`  out  1  request strobe to the bridge.
- `mem_write`  out  1  1 = write, 0 = read.
- `mem_addr`  out  SramAw  word address.
- `mem_wdata`  out  SramDw  write data.
- `mem_rvalid`  in  1  read-data response valid.
- `mem_rdata`  in  SramDw  read data.
- `mem_error`  in  2  bus error; meaningful only while `mem_rvalid`=1.
- `busy_o`  out  1  engine active.
- `done_o`  out  1  single-cycle pulse at completion.
- `pass_o`  out  1  last run had no errors and no timeout; held until next start.
- `timeout_o`  out  1  last run aborted on timeout; held until next start.
- `err_cnt_o`  out  16  mismatch/error count, saturating at 0xFFFF.
- `first_err_addr_o`  out  SramAw  address of the first failing read; 0 if none.

## Operation
- **States:** IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
- **IDLE → WRITE:** on `start_i`=1.
  - Capture the window and seed, load the LFSR, set `addr`=`start_addr`.
  - Clear `err_cnt_o`, `first_err_addr_o`, `pass_o` and `timeout_o`.
- **Empty window:** if `last_addr_i` < `start_addr_i`, go IDLE → DONE with no bus traffic and `pass_o`=1.
- **WRITE:**
  - One write per cycle: `mem_req`=1, `mem_write`=1, `mem_wdata`=LFSR state.
  - The LFSR advances after each issued word.
  - Writes are fire-and-forget; the bridge exposes no write acknowledge and no backpressure.
- **WRITE → READ_REQ:** after the write at `last_addr`.
  - Reload the LFSR from the seed.
  - Reset `addr` to `start_addr`.
- **READ_REQ:** one cycle with `mem_req`=1, `mem_write`=0, then go to READ_WAIT. At most one read is outstanding.
- **READ_WAIT:**
  - Wait for `mem_rvalid`.
  - A word fails if `mem_rdata` ≠ LFSR state, or if `mem_error` ≠ 0.
  - On a failure, increment `err_cnt_o` (saturating). On the first failure only, latch `addr` into `first_err_addr_o`.
  - Then advance the LFSR. Go to READ_REQ if `addr` ≠ `last_addr`, else go to DONE.
- **Timeout:** a `TimeoutCycles` counter restarts on entry to READ_WAIT. If it expires:
  - `timeout_o`=1, `err_cnt_o` is incremented, and `first_err_addr_o` is latched if this is the first failure.
  - Go to DONE.
- **DONE:**
  - `done_o`=1 for one cycle.
  - `pass_o` = (`err_cnt_o`==0 && !`timeout_o`).
  - Then go to IDLE.
- **Address end:** the end test compares against `last_addr` before incrementing, so `last_addr`=all-ones completes without wrapping.
- **Stray or early responses:** a `mem_rvalid` arriving outside READ_WAIT is ignored.
- **`start_i` while busy:** ignored.
- **LFSR:** 32-bit Galois, polynomial `LfsrPoly`=0x8020_0003, shifts once per word.

## Timing
- **Reset values:** all outputs are 0 on reset (including `pass_o`, `timeout_o` and `mem_*`); state is IDLE.
- **Reset mid-run:** aborts immediately with no further requests.
- **Registered outputs:** all outputs are registered.
  - First `mem_req` appears 1 cycle after `start_i` is sampled.
  - `busy_o` rises in that same cycle.
- **Write phase:** takes N cycles for N = `last`−`start`+1 words.
- **Read phase:** each word takes 1 (REQ) + response latency L (≥1) cycles in READ_WAIT.
- **`done_o`:** pulses 1 cycle after the final response.
- **`busy_o`:** falls in the same cycle `done_o` rises.

## Structure
- **Package `sram_bist_pkg`:** state enum `bist_state_e`, `LfsrPoly`, `DefaultSeed`=32'h1 (used when `seed_i`=0), and the width of `err_cnt_o` (`ErrCntW`=16).
- **Sub-module `sram_bist_lfsr`:** 32-bit Galois LFSR with `load_i`/`seed_i`/`en_i`/`state_o`. It is instantiated once, since write and read reuse the same sequence.

## Test plan
- **Clean run:** window 0x000–0x00F, seed 0x1, memory model with L=2 → 16 writes, then 16 reads; `done_o` pulses; `pass_o`=1, `err_cnt_o`=0.
- **Corrupted word:** model flips bit 0 of word 0x005 and of word 0x009 → `err_cnt_o`=2, `first_err_addr_o`=0x005, `pass_o`=0.
- **Bus error:** `mem_error`=2'b11 with correct data at 0x003 → `err_cnt_o`=1, `first_err_addr_o`=0x003.
- **Timeout:** model drops the read response at 0x007 → after 64 cycles in READ_WAIT, `timeout_o`=1, `pass_o`=0, `done_o` pulses, no further requests.
- **Boundary windows:**
  - start = last = 0xFFF → 1 write and 1 read, no wrap.
  - start 0x010, last 0x00F → `done_o` within 2 cycles, no `mem_req`, `pass_o`=1.
- **Reset and stray inputs:**
  - Assert `rst_ni`=0 during WRITE → `mem_req` drops immediately; all outputs are 0.
  - `start_i` held while busy → no restart.
  - A stray `mem_rvalid` while in WRITE → ignored.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM write/verify BIST engine.
// Includes the LFSR step used by both the write and the read phase.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadReq,
    StReadWait,
    StDone
  } bist_state_e;

  localparam logic [31:0] LfsrPoly    = 32'h8020_0003;
  localparam logic [31:0] DefaultSeed = 32'h0000_0001;
  localparam int          ErrCntW     = 16;

  // Right-shifting Galois form: feedback from bit 0 into the tap mask.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LfsrPoly : 32'h0);
  endfunction

endpackage

// File: rtl/sram_bist_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step enable.
// Load wins over enable so a reload can coincide with the last step.
module sram_bist_lfsr
  import sram_bist_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        en_i,
  output logic [31:0] state_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_o <= '0;
    end else if (load_i) begin
      state_o <= seed_i;
    end else if (en_i) begin
      state_o <= lfsr_next(state_o);
    end
  end

endmodule

// File: rtl/sram_bist_seq.sv
// Write-then-verify BIST sequencer for the SRAM request port of a
// TL-UL bridge: fills a window with an LFSR pattern and reads it back.
module sram_bist_seq
  import sram_bist_pkg::*;
#(
  parameter int SramAw        = 12,
  parameter int SramDw        = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [SramAw-1:0]  start_addr_i,
  input  logic [SramAw-1:0]  last_addr_i,
  input  logic [31:0]        seed_i,
  output logic               mem_req,
  output logic               mem_write,
  output logic [SramAw-1:0]  mem_addr,
  output logic [SramDw-1:0]  mem_wdata,
  input  logic               mem_rvalid,
  input  logic [SramDw-1:0]  mem_rdata,
  input  logic [1:0]         mem_error,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               timeout_o,
  output logic [ErrCntW-1:0] err_cnt_o,
  output logic [SramAw-1:0]  first_err_addr_o
);

  localparam int TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  bist_state_e       state_q;
  logic [SramAw-1:0] addr_q;
  logic [SramAw-1:0] start_q;
  logic [SramAw-1:0] last_q;
  logic [31:0]       seed_q;
  logic [31:0]       seed_in;
  logic [31:0]       lfsr_seed;
  logic [31:0]       lfsr_q;
  logic [TmoW-1:0]   tmo_q;
  logic [ErrCntW-1:0] err_inc;
  logic              lfsr_load;
  logic              lfsr_en;
  logic              at_last;
  logic              rd_fail;
  logic              empty_win;
  logic              first_fail;

  assign seed_in    = (seed_i == '0) ? DefaultSeed : seed_i;
  assign at_last    = addr_q == last_q;
  assign empty_win  = last_addr_i < start_addr_i;
  assign rd_fail    = (mem_rdata != lfsr_q) || (mem_error != 2'b00);
  assign err_inc    = (&err_cnt_o) ? err_cnt_o : err_cnt_o + ErrCntW'(1);
  assign first_fail = err_cnt_o == '0;

  // Same sequence serves both phases: reload on the last write.
  assign lfsr_load = (state_q == StIdle && start_i && !empty_win)
                  || (state_q == StWrite && at_last);
  assign lfsr_seed = (state_q == StIdle) ? seed_in : seed_q;
  assign lfsr_en   = (state_q == StWrite)
                  || (state_q == StReadWait && mem_rvalid);

  assign mem_addr  = addr_q;
  assign mem_wdata = lfsr_q;

  sram_bist_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (lfsr_load),
    .seed_i  (lfsr_seed),
    .en_i    (lfsr_en),
    .state_o (lfsr_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      addr_q           <= '0;
      start_q          <= '0;
      last_q           <= '0;
      seed_q           <= '0;
      tmo_q            <= '0;
      mem_req          <= 1'b0;
      mem_write        <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            start_q          <= start_addr_i;
            last_q           <= last_addr_i;
            seed_q           <= seed_in;
            addr_q           <= start_addr_i;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            timeout_o        <= 1'b0;
            if (empty_win) begin
              state_q <= StDone;
              done_o  <= 1'b1;
              pass_o  <= 1'b1;
            end else begin
              state_q   <= StWrite;
              pass_o    <= 1'b0;
              mem_req   <= 1'b1;
              mem_write <= 1'b1;
              busy_o    <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (at_last) begin
            state_q   <= StReadReq;
            addr_q    <= start_q;
            mem_write <= 1'b0;
          end else begin
            addr_q <= addr_q + SramAw'(1);
          end
        end
        StReadReq: begin
          state_q <= StReadWait;
          mem_req <= 1'b0;
          tmo_q   <= '0;
        end
        StReadWait: begin
          if (mem_rvalid) begin
            if (rd_fail) begin
              err_cnt_o <= err_inc;
              if (first_fail) first_err_addr_o <= addr_q;
            end
            if (at_last) begin
              state_q <= StDone;
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
              pass_o  <= !rd_fail && first_fail;
            end else begin
              state_q <= StReadReq;
              mem_req <= 1'b1;
              addr_q  <= addr_q + SramAw'(1);
            end
          end else if (tmo_q == TmoLast) begin
            timeout_o <= 1'b1;
            err_cnt_o <= err_inc;
            if (first_fail) first_err_addr_o <= addr_q;
            state_q   <= StDone;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            pass_o    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bist_seq.sv
// Scoreboard bench for sram_bist_seq: memory responder with fault
// injection, expected bus traffic and results from a reference model.
module tb_sram_bist_seq;

  localparam logic [31:0] Poly = 32'h8020_0003;
  localparam int          Tmo  = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [11:0] start_addr_i;
  logic [11:0] last_addr_i;
  logic [31:0] seed_i;
  logic        mem_req;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_error;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic        timeout_o;
  logic [15:0] err_cnt_o;
  logic [11:0] first_err_addr_o;

  sram_bist_seq dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .start_addr_i     (start_addr_i),
    .last_addr_i      (last_addr_i),
    .seed_i           (seed_i),
    .mem_req          (mem_req),
    .mem_write        (mem_write),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .mem_error        (mem_error),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .timeout_o        (timeout_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int err;
    int first;
    bit pass;
    bit tmo;
    int gap;
  } res_t;

  txn_t exp_q[$];
  res_t res_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_ev_cyc = 0;
  int results_seen = 0;
  int lat = 1;
  bit stray_en = 0;
  bit exp_pass = 0;

  logic [31:0] mem [4096];
  bit flip [4096];
  bit berr [4096];
  bit drop [4096];

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x % 2 == 1) y = y ^ Poly;
    return y;
  endfunction

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_faults();
    flip = '{default: 1'b0};
    berr = '{default: 1'b0};
    drop = '{default: 1'b0};
  endtask

  // Reference model: the whole run's traffic and verdict in one pass.
  task automatic expect_run(input int s, input int l,
                            input logic [31:0] seed, input int latency);
    logic [31:0] x;
    res_t r;
    bit have;
    txn_t t;
    r = '{err: 0, first: 0, pass: 0, tmo: 0, gap: 1};
    have = 0;
    x = (seed == 0) ? 32'h1 : seed;
    for (int a = s; a <= l; a++) begin
      t = '{wr: 1, addr: a, data: x};
      exp_q.push_back(t);
      x = ref_step(x);
    end
    for (int a = s; a <= l; a++) begin
      t = '{wr: 0, addr: a, data: 32'h0};
      exp_q.push_back(t);
      if (drop[a] || flip[a] || berr[a]) begin
        r.err++;
        if (!have) r.first = a;
        have = 1;
      end
      if (drop[a]) begin
        r.tmo = 1;
        break;
      end
    end
    r.pass = (r.err == 0);
    if (r.tmo) r.gap = Tmo + 1;
    else if (l >= s) r.gap = latency + 1;
    res_q.push_back(r);
    exp_pass = r.pass;
  endtask

  task automatic launch(input int s, input int l, input logic [31:0] seed);
    @(negedge clk_i);
    start_addr_i = s[11:0];
    last_addr_i  = l[11:0];
    seed_i       = seed;
    start_i      = 1'b1;
    last_ev_cyc  = cyc;
    @(negedge clk_i);
    chk("start_latency", {mem_req, busy_o}, (l >= s) ? 2'b11 : 2'b00);
  endtask

  task automatic run(input int s, input int l, input logic [31:0] seed,
                     input int latency, input bit hold);
    int target;
    lat = latency;
    target = results_seen + 1;
    expect_run(s, l, seed, latency);
    launch(s, l, seed);
    if (hold) repeat (2) @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 0; k < 2000 && results_seen < target; k++)
      @(negedge clk_i);
    if (results_seen < target) begin
      checks++;
      $display("FAIL done_wait: got no done_o expected one within 2000 cycles");
    end
    @(negedge clk_i);
    chk("post_done", {done_o, busy_o, pass_o, mem_req},
        {1'b0, 1'b0, exp_pass, 1'b0});
    chk("queue_drained", exp_q.size() + res_q.size(), 0);
    exp_q.delete();
    res_q.delete();
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    txn_t t;
    res_t r;
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1) begin
        if (mem_req) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_req: got req w=%0d addr %0h expected none",
                     mem_write, mem_addr);
          end else begin
            t = exp_q.pop_front();
            chk("bus_txn",
                {mem_write, mem_addr, t.wr ? mem_wdata : 32'h0},
                {t.wr, t.addr[11:0], t.data});
          end
          last_ev_cyc = cyc;
        end
        if (done_o) begin
          if (res_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got done_o expected none");
          end else begin
            r = res_q.pop_front();
            chk("result",
                {busy_o, pass_o, timeout_o, err_cnt_o, first_err_addr_o},
                {1'b0, r.pass, r.tmo, r.err[15:0], r.first[11:0]});
            chk("done_latency", cyc - last_ev_cyc, r.gap);
          end
          results_seen++;
        end
      end
    end
  end

  // Memory responder: fixed read latency, fault injection, stray beats.
  initial begin
    int pend = -1;
    int paddr = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_error  = '0;
    forever begin
      @(negedge clk_i);
      mem_rvalid = 1'b0;
      mem_error  = 2'b00;
      if (rst_ni !== 1'b1) pend = -1;
      if (pend > 0) pend--;
      if (pend == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[paddr] ^ (flip[paddr] ? 32'h1 : 32'h0);
        mem_error  = berr[paddr] ? 2'b11 : 2'b00;
        pend = -1;
      end
      if (rst_ni === 1'b1 && mem_req) begin
        if (mem_write) begin
          mem[mem_addr] = mem_wdata;
          if (stray_en) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            mem_error  = 2'b11;
            stray_en   = 0;
          end
        end else if (!drop[mem_addr]) begin
          pend  = lat;
          paddr = mem_addr;
        end
      end
    end
  end

  initial begin
    int s, n, l;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    start_addr_i = '0;
    last_addr_i  = '0;
    seed_i       = '0;
    clear_faults();
    repeat (3) @(negedge clk_i);
    chk("reset_bus", {mem_req, mem_write, mem_addr, mem_wdata}, 0);
    chk("reset_status", {busy_o, done_o, pass_o, timeout_o,
                         err_cnt_o, first_err_addr_o}, 0);
    rst_ni = 1'b1;

    run(0, 15, 32'h1, 2, 1);
    flip[5] = 1;
    flip[9] = 1;
    run(0, 15, 32'h1, 2, 0);
    clear_faults();
    berr[3] = 1;
    run(0, 15, $urandom, 2, 0);
    clear_faults();
    drop[7] = 1;
    run(0, 15, 32'h1, 2, 0);
    clear_faults();
    run(4095, 4095, $urandom, 1, 0);
    run(16, 15, $urandom, 1, 0);
    run(32, 40, 32'h0, 3, 0);
    stray_en = 1;
    run(0, 9, $urandom, 1, 0);

    // Abort mid-write: everything must drop asynchronously.
    expect_run(0, 15, 32'h1234_5678, 1);
    launch(0, 15, 32'h1234_5678);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("abort_bus", {mem_req, mem_write, mem_addr, mem_wdata}, 0);
    chk("abort_status", {busy_o, done_o, pass_o, timeout_o,
                         err_cnt_o, first_err_addr_o}, 0);
    exp_q.delete();
    res_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    run(100, 107, 32'hCAFE_F00D, 2, 0);

    for (int r = 0; r < 12; r++) begin
      clear_faults();
      s = $urandom_range(1, 4000);
      n = $urandom_range(0, 12);
      l = s + n - 1;
      if (n > 0 && $urandom_range(0, 2) == 0)
        flip[s + $urandom_range(0, n - 1)] = 1;
      if (n > 0 && $urandom_range(0, 2) == 0)
        berr[s + $urandom_range(0, n - 1)] = 1;
      if (n > 0 && $urandom_range(0, 4) == 0)
        drop[s + $urandom_range(0, n - 1)] = 1;
      run(s, l, $urandom, $urandom_range(1, 4), r[0] && n > 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
